// File: rtl/float_conv_pkg.sv
// Shared constants and helpers for the float_conv_mc DQ -> DQ0 converter.
// Field offsets and ZERO_MANT describe the default {sign, exp, mant} layout.
package float_conv_pkg;

    localparam int unsigned DEF_MAG_W  = 15;
    localparam int unsigned DEF_EXP_W  = 4;
    localparam int unsigned DEF_MANT_W = 6;
    localparam int unsigned DEF_NCH    = 8;

    localparam int unsigned MANT_LSB  = 0;
    localparam int unsigned EXP_LSB   = DEF_MANT_W;
    localparam int unsigned SIGN_POS  = DEF_MANT_W + DEF_EXP_W;
    localparam int unsigned ZERO_MANT = 1 << (DEF_MANT_W - 1);

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r = 0;
        int unsigned x = 1;
        while (x < v) begin
            x = x << 1;
            r++;
        end
        return r;
    endfunction

    // Channel tag width never collapses to zero bits, even for a single channel.
    function automatic int unsigned ch_width(input int unsigned nch);
        return (clog2(nch) > 0) ? clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/float_conv_lzd.sv
// Combinational leading-one detector: exponent = MSB index + 1, or 0 with a
// zero flag when the magnitude is all zeros.
module float_conv_lzd
    import float_conv_pkg::*;
#(
    parameter int unsigned MAG_W = DEF_MAG_W,
    parameter int unsigned EXP_W = DEF_EXP_W
) (
    input  logic [MAG_W-1:0] i_mag,
    output logic [EXP_W-1:0] o_exp,
    output logic             o_zero
);

    always_comb begin
        o_exp  = '0;
        o_zero = (i_mag == '0);
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (i_mag[i]) o_exp = EXP_W'(i + 1);
        end
    end

endmodule

// File: rtl/float_conv_mc.sv
// Multi-channel 2-stage DQ -> DQ0 floating-point converter with valid/ready
// streaming and channel tags. FLOAT_CONV_STATS_EN adds zero-magnitude counters.
module float_conv_mc
    import float_conv_pkg::*;
#(
    parameter int unsigned MAG_W  = DEF_MAG_W,
    parameter int unsigned EXP_W  = DEF_EXP_W,
    parameter int unsigned MANT_W = DEF_MANT_W,
    parameter int unsigned NCH    = DEF_NCH,
    localparam int unsigned CH_W  = ch_width(NCH),
    localparam int unsigned OUT_W = 1 + EXP_W + MANT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              scan_in0,
    input  logic              scan_in1,
    input  logic              scan_in2,
    input  logic              scan_in3,
    input  logic              scan_in4,
    input  logic              scan_enable,
    input  logic              test_mode,
    output logic              scan_out0,
    output logic              scan_out1,
    output logic              scan_out2,
    output logic              scan_out3,
    output logic              scan_out4,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [MAG_W:0]    DQ,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [OUT_W-1:0]  DQ0
`ifdef FLOAT_CONV_STATS_EN
    ,
    input  logic [CH_W-1:0]   stat_ch,
    output logic [15:0]       stat_cnt
`endif
);

    localparam logic [MANT_W-1:0] L_ZERO_MANT = MANT_W'(1) << (MANT_W - 1);

    logic              r_ready_en;
    logic              r_s1_valid;
    logic [MAG_W-1:0]  r_s1_mag;
    logic              r_s1_sign;
    logic [CH_W-1:0]   r_s1_ch;
    logic [EXP_W-1:0]  r_s1_exp;
    logic              r_s1_zero;
    logic              r_s2_valid;
    logic              r_s2_sign;
    logic [EXP_W-1:0]  r_s2_exp;
    logic [MANT_W-1:0] r_s2_mant;
    logic [CH_W-1:0]   r_s2_ch;

    logic [EXP_W-1:0]  w_in_exp;
    logic              w_in_zero;
    logic              w_s2_load;
    logic              w_s1_load;
    logic              w_accept;
    logic [MANT_W-1:0] w_mant;

    assign scan_out0 = test_mode & scan_enable & scan_in0;
    assign scan_out1 = test_mode & scan_enable & scan_in1;
    assign scan_out2 = test_mode & scan_enable & scan_in2;
    assign scan_out3 = test_mode & scan_enable & scan_in3;
    assign scan_out4 = test_mode & scan_enable & scan_in4;

    float_conv_lzd #(
        .MAG_W (MAG_W),
        .EXP_W (EXP_W)
    ) u_lzd (
        .i_mag  (DQ[MAG_W-1:0]),
        .o_exp  (w_in_exp),
        .o_zero (w_in_zero)
    );

    // S1 may fill behind a stalled S2 when empty, so in_ready reduces to the
    // !s2_valid || out_ready || !s1_valid form.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = r_ready_en && !flush && w_s1_load;
    assign w_accept  = in_valid && in_ready;

    assign w_mant = r_s1_zero ? L_ZERO_MANT
                              : MANT_W'({r_s1_mag, {MANT_W{1'b0}}} >> r_s1_exp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_ready_en <= 1'b0;
        else        r_ready_en <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
            r_s1_mag   <= '0;
            r_s1_sign  <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_exp   <= '0;
            r_s1_zero  <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_mag  <= DQ[MAG_W-1:0];
                r_s1_sign <= DQ[MAG_W];
                r_s1_ch   <= in_ch;
                r_s1_exp  <= w_in_exp;
                r_s1_zero <= w_in_zero;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_exp   <= '0;
            r_s2_mant  <= '0;
            r_s2_ch    <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_exp  <= r_s1_exp;
                r_s2_mant <= w_mant;
                r_s2_ch   <= r_s1_ch;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out_ch    = r_s2_ch;
    assign DQ0       = {r_s2_sign, r_s2_exp, r_s2_mant};

`ifdef FLOAT_CONV_STATS_EN
    logic [15:0] r_zcnt [NCH];
    logic [15:0] r_stat_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCH; i++) r_zcnt[i] <= '0;
            r_stat_cnt <= '0;
        end else begin
            if (flush) begin
                for (int unsigned i = 0; i < NCH; i++) r_zcnt[i] <= '0;
            end else if (w_accept && w_in_zero) begin
                r_zcnt[in_ch] <= r_zcnt[in_ch] + 16'd1;
            end
            r_stat_cnt <= (32'(stat_ch) < NCH) ? r_zcnt[stat_ch] : '0;
        end
    end

    assign stat_cnt = r_stat_cnt;
`endif

endmodule

// File: tb/tb_float_conv_mc.sv
// Self-checking bench for float_conv_mc: golden vectors, randomized streaming
// against a queue-based reference, backpressure, flush, reset and wide widths.
`timescale 1ns/1ps
module tb_float_conv_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_ch, out_ch;
    logic [15:0] DQ;
    logic [10:0] DQ0;
    logic [4:0]  scan_o, w_scan_o;
    logic        scan_en, tmode;

    logic        w_in_valid, w_in_ready, w_out_valid;
    logic [2:0]  w_in_ch, w_out_ch;
    logic [23:0] w_dq;
    logic [13:0] w_dq0;

`ifdef FLOAT_CONV_STATS_EN
    logic [2:0]  stat_ch, w_stat_ch;
    logic [15:0] stat_cnt, w_stat_cnt;
`endif

    float_conv_mc u_dut (
        .clk(clk), .reset(reset),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
        .scan_enable(scan_en), .test_mode(tmode),
        .scan_out0(scan_o[0]), .scan_out1(scan_o[1]), .scan_out2(scan_o[2]),
        .scan_out3(scan_o[3]), .scan_out4(scan_o[4]),
        .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .DQ(DQ),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .DQ0(DQ0)
`ifdef FLOAT_CONV_STATS_EN
        , .stat_ch(stat_ch), .stat_cnt(stat_cnt)
`endif
    );

    float_conv_mc #(.MAG_W(23), .EXP_W(5), .MANT_W(8), .NCH(8)) u_wide (
        .clk(clk), .reset(reset),
        .scan_in0(1'b0), .scan_in1(1'b0), .scan_in2(1'b0), .scan_in3(1'b0), .scan_in4(1'b0),
        .scan_enable(scan_en), .test_mode(tmode),
        .scan_out0(w_scan_o[0]), .scan_out1(w_scan_o[1]), .scan_out2(w_scan_o[2]),
        .scan_out3(w_scan_o[3]), .scan_out4(w_scan_o[4]),
        .flush(1'b0), .in_valid(w_in_valid), .in_ready(w_in_ready), .in_ch(w_in_ch), .DQ(w_dq),
        .out_valid(w_out_valid), .out_ready(1'b1), .out_ch(w_out_ch), .DQ0(w_dq0)
`ifdef FLOAT_CONV_STATS_EN
        , .stat_ch(w_stat_ch), .stat_cnt(w_stat_cnt)
`endif
    );

    typedef struct {
        logic [2:0]  ch;
        logic [10:0] dq0;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          n_acc = 0;
    bit          lat_chk = 1'b0;
    bit          use_gold = 1'b0;
    logic [10:0] gold;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", tag, act, req, $time);
        end
    endtask

    // Reference: exponent = bit length of magnitude, mantissa = mag*2^N/2^E mod 2^N.
    function automatic longint unsigned ref_dq0(input int unsigned mw, input int unsigned ew,
                                                input int unsigned nw, input longint unsigned dq);
        longint unsigned mag = dq % (64'd1 << mw);
        longint unsigned sgn = (dq >> mw) % 2;
        longint unsigned e = 0;
        longint unsigned mant;
        while ((64'd1 << e) <= mag) e++;
        if (mag == 0) mant = 64'd1 << (nw - 1);
        else          mant = ((mag * (64'd1 << nw)) / (64'd1 << e)) % (64'd1 << nw);
        return (sgn << (ew + nw)) + (e << nw) + mant;
    endfunction

    task automatic tick();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                check("dq0", DQ0, sb[0].dq0);
                check("out_ch", out_ch, sb[0].ch);
                if (lat_chk && out_ready) check("latency", cyc - sb[0].cyc, 2);
                if (out_ready) void'(sb.pop_front());
            end
        end else if (lat_chk && sb.size() > 0 && (cyc - sb[0].cyc) >= 2) begin
            check("late_out", out_valid, 1);
        end
        if (flush) check("flush_in_ready", in_ready, 0);
        if (in_valid && in_ready) begin
            e.ch  = in_ch;
            e.dq0 = use_gold ? gold : 11'(ref_dq0(15, 4, 6, 64'(DQ)));
            e.cyc = cyc;
            sb.push_back(e);
            n_acc++;
        end
        if (flush) sb.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) tick();
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] gv [4];
        logic [10:0] gd [4];
        gv[0] = 16'h0000; gd[0] = 11'h020;
        gv[1] = 16'h0001; gd[1] = 11'h060;
        gv[2] = 16'h7FFF; gd[2] = 11'h3FF;
        gv[3] = 16'h8040; gd[3] = 11'h5E0;

        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_ch = '0; DQ = '0; scan_en = 1'b0; tmode = 1'b0;
        w_in_valid = 1'b0; w_in_ch = '0; w_dq = '0;
`ifdef FLOAT_CONV_STATS_EN
        stat_ch = '0; w_stat_ch = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_dq0", DQ0, 0);
        check("rst_out_ch", out_ch, 0);
        check("rst_in_ready", in_ready, 0);
        reset = 1'b1;
        @(negedge clk);
        check("ready_before_edge", in_ready, 0);
        @(posedge clk);
        #1;
        check("ready_after_reset", in_ready, 1);

        // golden vectors, back-to-back
        lat_chk = 1'b1; use_gold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; DQ = gv[i]; gold = gd[i]; in_ch = 3'(i);
            tick();
        end
        use_gold = 1'b0;
        drain(4);

        // backpressure: only two samples fit while stalled
        lat_chk = 1'b0; out_ready = 1'b0; n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; DQ = 16'($urandom); in_ch = 3'(i);
            tick();
        end
        check("bp_accepts", n_acc, 2);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            DQ = 16'($urandom); in_ch = 3'(5 + i);
            tick();
        end
        drain(5);

        // channel interleave
        lat_chk = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; DQ = 16'($urandom); in_ch = 3'(i);
            tick();
        end
        drain(4);

        // randomized traffic with random backpressure
        lat_chk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(3, 0) != 0);
            out_ready = ($urandom_range(9, 0) < 7);
            in_ch = 3'($urandom);
            case ($urandom_range(3, 0))
                0: DQ = {1'($urandom), 15'h0};
                1: DQ = 16'(1 << $urandom_range(15, 0));
                default: DQ = 16'($urandom);
            endcase
            tick();
        end
        drain(20);

        // flush with two samples in flight
        in_valid = 1'b1; out_ready = 1'b1;
        DQ = 16'h1234; in_ch = 3'd1; tick();
        DQ = 16'h0777; in_ch = 3'd2; tick();
        flush = 1'b1; out_ready = 1'b0; DQ = 16'h0555; in_ch = 3'd3;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 0);
        drain(4);

        // asynchronous reset mid-stream
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            DQ = 16'($urandom); in_ch = 3'(i); tick();
        end
        #2 reset = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_dq0", DQ0, 0);
        check("arst_out_ch", out_ch, 0);
        check("arst_in_ready", in_ready, 0);
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("rearm_in_ready", in_ready, 1);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; DQ = 16'($urandom); in_ch = 3'(i); tick();
        end
        drain(4);

        // wide instance: MAG_W=23, EXP_W=5, MANT_W=8
        w_in_valid = 1'b1; w_dq = 24'h400000; w_in_ch = 3'd6;
        @(posedge clk); #1;
        w_dq = 24'h000000; w_in_ch = 3'd7;
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        check("wide_valid_a", w_out_valid, 1);
        check("wide_dq0_a", w_dq0, 14'h1780);
        check("wide_ch_a", w_out_ch, 6);
        @(posedge clk); #1;
        check("wide_dq0_b", w_dq0, 14'h0080);
        check("wide_ch_b", w_out_ch, 7);
        for (int i = 0; i < 6; i++) begin
            logic [23:0] v;
            v = 24'($urandom);
            w_in_valid = 1'b1; w_dq = v;
            @(posedge clk); #1;
            w_in_valid = 1'b0;
            @(posedge clk); #1;
            check("wide_rand", w_dq0, 14'(ref_dq0(23, 5, 8, 64'(v))));
        end

`ifdef FLOAT_CONV_STATS_EN
        flush = 1'b1; tick(); flush = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_ch = 3'd2;
        DQ = 16'h0000; tick();
        DQ = 16'h0005; tick();
        DQ = 16'h8000; tick();
        DQ = 16'h0000; tick();
        in_valid = 1'b0; stat_ch = 3'd2;
        tick(); tick();
        check("stat_ch2", stat_cnt, 16'd3);
        stat_ch = 3'd5; in_ch = 3'd5; DQ = 16'h0000; in_valid = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        in_valid = 1'b0;
        tick(); tick();
        check("stat_full", stat_cnt, 16'hFFFF);
        in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick(); tick();
        check("stat_wrap", stat_cnt, 16'h0000);
        drain(4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/float_conv_mc.md
Name: float_conv_mc

Overview:
- Multi-channel, parametrised successor to the G.726 FLOATA stage.
- Converts sign-magnitude quantised difference samples (DQ) into the ITU floating format {sign, exponent, mantissa} (DQ0).
- Adds a valid/ready streaming interface, a 2-stage pipeline with full-throughput backpressure, and channel-tag passthrough.
- Time-multiplexed channels of the ADPCM datapath share one converter instance.

Parameters:
- MAG_W, 15, magnitude bits of input (input width MAG_W+1).
- EXP_W, 4, exponent bits; must satisfy 2^EXP_W > MAG_W.
- MANT_W, 6, mantissa bits.
- NCH, 8, channel count; tag width CH_W = max(1, clog2(NCH)).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- scan_in0..scan_in4  in  1 each  scan chain inputs.
- scan_enable  in  1  scan shift enable.
- test_mode  in  1  test mode select.
- scan_out0..scan_out4  out  1 each  scan chain outputs.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  input sample valid.
- in_ready  out  1  converter can accept.
- in_ch  in  CH_W  channel tag of input.
- DQ  in  MAG_W+1  bit MAG_W = sign, [MAG_W-1:0] = magnitude.
- out_valid  out  1  DQ0 valid.
- out_ready  in  1  downstream accepts.
- out_ch  out  CH_W  channel tag of DQ0.
- DQ0  out  1+EXP_W+MANT_W  {sign, exp, mant}.

Behaviour:
- Arithmetic, bit-exact to G.726 FLOATA at default widths:
  - MAG = DQ[MAG_W-1:0]; sign = DQ[MAG_W].
  - EXP = 0 if MAG==0, else index of MSB of MAG + 1.
  - MANT = 2^(MANT_W-1) if MAG==0, else ((MAG << MANT_W) >> EXP) truncated to MANT_W bits.
  - Sign passes through unchanged, including negative zero.
- Pipeline:
  - S1 registers MAG, sign, ch and the leading-one position.
  - S2 registers the shifted mantissa, exponent and tag.
  - Latency: 2 cycles from an accepted input to out_valid.
- Handshake:
  - A transfer occurs when valid && ready on that edge.
  - in_ready = !s2_valid || out_ready || !s1_valid (combinational). The pipeline advances as a whole; a bubble in S1 is collapsed while S2 is stalled.
  - A stage advances only when its downstream slot is empty or being drained that cycle.
  - Sustained throughput is 1 sample/clk when out_ready=1.
- Output stability: while out_valid=1 and out_ready=0, DQ0 and out_ch hold stable; out_valid does not drop until the transfer completes.
- flush:
  - Clears s1_valid and s2_valid on the next edge and forces in_ready=0 for that cycle.
  - flush has priority over a simultaneous in_valid; that input is not accepted.
- Reset (async, active-low): out_valid=0, DQ0=0, out_ch=0, all stage registers 0.
  - in_ready reads 1 one cycle after reset deasserts; it is 0 while reset is asserted.
  - Reset mid-stream discards in-flight samples.
- Channel tags are opaque; no reordering, so out_ch order equals in_ch order.

Optional Feature:
- FLOAT_CONV_STATS_EN defined:
  - Adds per-channel 16-bit zero-magnitude counters, incremented on each accepted input with MAG==0.
  - Counters wrap 0xFFFF to 0x0000.
  - Adds ports stat_ch (in, CH_W) and stat_cnt (out, 16) holding the registered count, 1-cycle read latency.
  - Counters clear on reset and on flush.
- Undefined: no counters and no stat ports.

Decomposition:
- Package float_conv_pkg holds:
  - default widths;
  - clog2 function;
  - DQ0 field offset constants (SIGN_POS, EXP_LSB, MANT_LSB);
  - ZERO_MANT = 2^(MANT_W-1).
- Sub-module float_conv_lzd: combinational leading-one detector of MAG_W bits, returning EXP and a zero flag.

Test Plan:
- Default widths, streaming, out_ready=1:
  - DQ=0x0000 -> DQ0=0x020.
  - DQ=0x0001 -> 0x060.
  - DQ=0x7FFF -> 0x3FF.
  - DQ=0x8040 -> 0x5E0 (sign 1, exp 7, mant 32).
  - Each appears exactly 2 cycles after acceptance, back-to-back.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1.
  - Exactly 2 samples are accepted, then in_ready=0; DQ0 and out_ch stay stable.
  - Release -> remaining samples drain in order, with no loss or duplication.
- Channel interleave, NCH=8: tags 0..7 with the ITU dq.t vectors per channel -> out_ch sequence 0..7, DQ0 matching the dq0.t golden files for all rates and laws.
- Flush and reset:
  - Assert flush with 2 samples in flight -> out_valid=0 next cycle; the sample offered in the flush cycle is not accepted.
  - Drop reset mid-stream -> out_valid=0 and DQ0=0 immediately (async).
- Parametrised widths MAG_W=23, EXP_W=5, MANT_W=8: MAG=0x400000 -> exp 23, mant 0x80; MAG=0 -> exp 0, mant 0x80.
- FLOAT_CONV_STATS_EN:
  - 3 zero samples on ch 2 -> stat_ch=2 reads 3.
  - Preload 0xFFFF plus 1 zero sample -> reads 0x0000.
